// File: rtl/wall_pkg.sv
// Shared constants and FSM encoding for the wall-collision checker and the
// wall renderer that reuses the map ROM.
package wall_pkg;

    localparam int SQUARE_SIDE = 60;   // tile and sprite edge in pixels
    localparam int ORIGIN_X    = 62;   // x pixel of tile column 0
    localparam int ORIGIN_Y    = 108;  // y pixel of tile row 0
    localparam int MAP_COLS    = 15;
    localparam int MAP_ROWS    = 10;

    localparam int COORD_W = 12;       // requester coordinate width
    localparam int SUM_W   = 13;       // one extra bit so x+SIDE never wraps

    localparam logic [SUM_W-1:0] SIDE_S   = SUM_W'(SQUARE_SIDE);
    localparam logic [SUM_W-1:0] ORIGIN_XS = SUM_W'(ORIGIN_X);
    localparam logic [SUM_W-1:0] ORIGIN_YS = SUM_W'(ORIGIN_Y);
    localparam logic [3:0]       LAST_COL  = 4'(MAP_COLS - 1);
    localparam logic [3:0]       LAST_ROW  = 4'(MAP_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/wall_collision_arbiter_if.sv
// Request/verdict bundle between the two sprite movement controllers
// (master side) and the shared collision checker (slave side).
interface wall_collision_arbiter_if;
    import wall_pkg::*;

    logic               req_0;
    logic [COORD_W-1:0] x_0;
    logic [COORD_W-1:0] y_0;
    logic               req_1;
    logic [COORD_W-1:0] x_1;
    logic [COORD_W-1:0] y_1;
    logic               ack_0;
    logic               ack_1;
    logic               hit_0;
    logic               hit_1;
    logic               busy;

    modport master (
        output req_0, x_0, y_0, req_1, x_1, y_1,
        input  ack_0, ack_1, hit_0, hit_1, busy
    );

    modport slave (
        input  req_0, x_0, y_0, req_1, x_1, y_1,
        output ack_0, ack_1, hit_0, hit_1, busy
    );

endinterface

// File: rtl/wall_map_rom.sv
// Fixed playfield wall map: one 15-bit bitmap per row, bit col set = wall.
// Rows outside the map read as empty so scanners need no range guard.
module wall_map_rom
    import wall_pkg::*;
(
    input  logic [3:0]          row,
    output logic [MAP_COLS-1:0] bits
);

    // Row lookup; only rows 1, 2 and 5 carry walls.
    always_comb begin
        bits = '0;
        case (row)
            4'd1:    bits = 15'b000_0000_0000_0110;  // cols 1 and 2
            4'd2:    bits = 15'b000_0000_0000_0010;  // col 1
            4'd5:    bits = 15'b000_0000_0000_1000;  // col 3
            default: bits = '0;
        endcase
    end

endmodule

// File: rtl/wall_collision_arbiter.sv
// Time-shared wall-collision checker. Two requesters are arbitrated
// round-robin; the granted position is tested against one map tile per
// clock in row-major order, stopping at the first overlapping wall.
module wall_collision_arbiter
    import wall_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    wall_collision_arbiter_if.slave bus
);

    state_t           state_reg;
    logic             rr_reg;       // preferred requester on a tie
    logic             grant_reg;    // requester currently being served
    logic [3:0]       col_reg;
    logic [3:0]       row_reg;
    logic [SUM_W-1:0] bx_reg;       // pixel x of current tile, stepped by +SIDE
    logic [SUM_W-1:0] by_reg;       // pixel y of current tile, stepped by +SIDE
    logic [SUM_W-1:0] hx_reg;
    logic [SUM_W-1:0] hy_reg;
    logic [1:0]       ack_reg;
    logic [1:0]       hit_reg;
    logic             busy_reg;

    logic [MAP_COLS-1:0] row_bits;
    logic [15:0]         row_ext;
    logic                req_any;
    logic                grant_sel;
    logic                overlap;
    logic                cell_hit;
    logic                last_cell;

    wall_map_rom u_rom (
        .row  (row_reg),
        .bits (row_bits)
    );

    // Pad to a power-of-two width so the 4-bit column index is always in range.
    assign row_ext = {1'b0, row_bits};

    // A lone request wins outright; a tie goes to the round-robin pointer.
    assign req_any   = bus.req_0 | bus.req_1;
    assign grant_sel = (bus.req_0 & bus.req_1) ? rr_reg : bus.req_1;

    // Strict inequalities: sprites touching a wall edge are not blocked.
    assign overlap = (hx_reg < bx_reg + SIDE_S) && (hx_reg + SIDE_S > bx_reg) &&
                     (hy_reg < by_reg + SIDE_S) && (hy_reg + SIDE_S > by_reg);
    assign cell_hit  = row_ext[col_reg] & overlap;
    assign last_cell = (row_reg == LAST_ROW) && (col_reg == LAST_COL);

    // Arbitration, tile scan and verdict registers in one state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            rr_reg    <= 1'b0;
            grant_reg <= 1'b0;
            col_reg   <= '0;
            row_reg   <= '0;
            bx_reg    <= ORIGIN_XS;
            by_reg    <= ORIGIN_YS;
            hx_reg    <= '0;
            hy_reg    <= '0;
            ack_reg   <= '0;
            hit_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= '0;
                    if (req_any) begin
                        grant_reg <= grant_sel;
                        rr_reg    <= ~grant_sel;
                        hx_reg    <= grant_sel ? {1'b0, bus.x_1} : {1'b0, bus.x_0};
                        hy_reg    <= grant_sel ? {1'b0, bus.y_1} : {1'b0, bus.y_0};
                        col_reg   <= '0;
                        row_reg   <= '0;
                        bx_reg    <= ORIGIN_XS;
                        by_reg    <= ORIGIN_YS;
                        busy_reg  <= 1'b1;
                        state_reg <= SCAN;
                    end
                end
                SCAN: begin
                    if (cell_hit || last_cell) begin
                        ack_reg[grant_reg] <= 1'b1;
                        hit_reg[grant_reg] <= cell_hit;
                        state_reg          <= DONE;
                    end else if (col_reg == LAST_COL) begin
                        col_reg <= '0;
                        row_reg <= row_reg + 4'd1;
                        bx_reg  <= ORIGIN_XS;
                        by_reg  <= by_reg + SIDE_S;
                    end else begin
                        col_reg <= col_reg + 4'd1;
                        bx_reg  <= bx_reg + SIDE_S;
                    end
                end
                DONE: begin
                    ack_reg   <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack_reg   <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack_0 = ack_reg[0];
    assign bus.ack_1 = ack_reg[1];
    assign bus.hit_0 = hit_reg[0];
    assign bus.hit_1 = hit_reg[1];
    assign bus.busy  = busy_reg;

endmodule

// File: tb/tb_wall_collision_arbiter.sv
// Directed bench for wall_collision_arbiter: latency, verdicts, arbitration
// order and mid-scan reset, with hand-computed expectations.
module tb_wall_collision_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    wall_collision_arbiter_if bus ();

    wall_collision_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Issue one request from an idle arbiter and time it from the grant edge.
    task automatic serve(input int who, input logic [11:0] x, input logic [11:0] y,
                         input bit scramble, output int lat, output logic hv,
                         output bit ok, output bit other_ack);
        int n;
        ok = 1'b1; other_ack = 1'b0; lat = 0; hv = 1'bx;
        if (who == 0) begin bus.x_0 = x; bus.y_0 = y; bus.req_0 = 1'b1; end
        else          begin bus.x_1 = x; bus.y_1 = y; bus.req_1 = 1'b1; end
        n = 0;
        do begin tick(); n++; end while (!bus.busy && n < 400);
        if (!bus.busy) ok = 1'b0;
        if (scramble) begin
            bus.x_0 = 12'd0; bus.y_0 = 12'd0; bus.x_1 = 12'd0; bus.y_1 = 12'd0;
        end
        while (ok) begin
            tick(); lat++;
            if ((who == 0 && bus.ack_1) || (who == 1 && bus.ack_0)) other_ack = 1'b1;
            if ((who == 0 && bus.ack_0) || (who == 1 && bus.ack_1)) break;
            if (lat > 300) ok = 1'b0;
        end
        hv = (who == 0) ? bus.hit_0 : bus.hit_1;
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp += 5;
        if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        if (bus.ack_0 !== 1'b0) begin n_fail++; $display("FAIL rst_ack0 got=%b want=0", bus.ack_0); end
        if (bus.ack_1 !== 1'b0) begin n_fail++; $display("FAIL rst_ack1 got=%b want=0", bus.ack_1); end
        if (bus.hit_0 !== 1'b0) begin n_fail++; $display("FAIL rst_hit0 got=%b want=0", bus.hit_0); end
        if (bus.hit_1 !== 1'b0) begin n_fail++; $display("FAIL rst_hit1 got=%b want=0", bus.hit_1); end
        $display("reset: outputs checked");
    endtask

    // Run one request and compare latency/verdict against hand values.
    task automatic check_req(input string name, input int who, input logic [11:0] x,
                             input logic [11:0] y, input bit scramble,
                             input int exp_lat, input logic exp_hit);
        int lat; logic hv; bit ok; bit oa;
        serve(who, x, y, scramble, lat, hv, ok, oa);
        n_cmp += 3;
        if (!ok || lat !== exp_lat) begin n_fail++; $display("FAIL %s_lat got=%0d ok=%0b want=%0d", name, lat, ok, exp_lat); end
        if (hv !== exp_hit) begin n_fail++; $display("FAIL %s_hit got=%b want=%b", name, hv, exp_hit); end
        if (oa) begin n_fail++; $display("FAIL %s_other_ack got=1 want=0", name); end
        $display("req%0d (%0d,%0d): ack at cycle %0d hit=%b", who, x, y, lat, hv);
    endtask

    task automatic test_early_hit();
        check_req("early_hit", 0, 12'd122, 12'd168, 1'b1, 17, 1'b1);
    endtask

    task automatic test_edge_contact();
        check_req("edge_miss", 0, 12'd62, 12'd168, 1'b0, 150, 1'b0);
        check_req("edge_hit",  0, 12'd63, 12'd168, 1'b0, 17,  1'b1);
    endtask

    task automatic test_late_wall();
        check_req("late_wall", 1, 12'd250,  12'd400,  1'b0, 79,  1'b1);
        check_req("max_coord", 1, 12'd4095, 12'd4095, 1'b0, 150, 1'b0);
    endtask

    // Both requesters ask together; first/second winner come from rr pointer.
    task automatic dual(input string name, input int first);
        int n; int lat; bit f0; bit f1; int gap;
        bus.x_0 = 12'd122; bus.y_0 = 12'd168; bus.x_1 = 12'd122; bus.y_1 = 12'd168;
        bus.req_0 = 1'b1; bus.req_1 = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.busy && n < 50);
        lat = 0; f0 = 1'b0; f1 = 1'b0;
        do begin tick(); lat++; f0 = bus.ack_0; f1 = bus.ack_1; end while (!f0 && !f1 && lat < 300);
        n_cmp += 2;
        if ((first == 0 && !(f0 && !f1)) || (first == 1 && !(f1 && !f0)))
            begin n_fail++; $display("FAIL %s_first got ack0=%b ack1=%b want winner=%0d", name, f0, f1, first); end
        if (lat !== 17) begin n_fail++; $display("FAIL %s_first_lat got=%0d want=17", name, lat); end
        if (first == 0) bus.req_0 = 1'b0; else bus.req_1 = 1'b0;
        gap = 0;
        do begin tick(); gap++; end while (!bus.busy && gap < 50);
        n_cmp += 1;
        if (gap !== 2) begin n_fail++; $display("FAIL %s_gap got=%0d want=2", name, gap); end
        lat = 0; f0 = 1'b0; f1 = 1'b0;
        do begin tick(); lat++; f0 = bus.ack_0; f1 = bus.ack_1; end while (!f0 && !f1 && lat < 300);
        n_cmp += 2;
        if ((first == 0 && !(f1 && !f0)) || (first == 1 && !(f0 && !f1)))
            begin n_fail++; $display("FAIL %s_second got ack0=%b ack1=%b want winner=%0d", name, f0, f1, 1 - first); end
        if (lat !== 17) begin n_fail++; $display("FAIL %s_second_lat got=%0d want=17", name, lat); end
        bus.req_0 = 1'b0; bus.req_1 = 1'b0;
        tick();
        $display("%s: winner %0d then %0d, idle gap %0d", name, first, 1 - first, gap);
    endtask

    task automatic test_arbitration();
        apply_reset();
        dual("arb_a", 0);               // pointer 0 after reset
        check_req("arb_lone", 0, 12'd122, 12'd168, 1'b0, 17, 1'b1);  // pointer now 1
        dual("arb_b", 1);
    endtask

    task automatic test_reset_mid_scan();
        int n; bit seen;
        check_req("pre_rst", 0, 12'd122, 12'd168, 1'b0, 17, 1'b1);   // hit_0 now 1
        bus.x_0 = 12'd0; bus.y_0 = 12'd0; bus.req_0 = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!bus.busy && n < 50);
        for (int i = 0; i < 40; i++) tick();
        rst = 1'b1; bus.req_0 = 1'b0;
        tick();
        n_cmp += 3;
        if (bus.busy  !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        if (bus.ack_0 !== 1'b0) begin n_fail++; $display("FAIL midrst_ack0 got=%b want=0", bus.ack_0); end
        if (bus.hit_0 !== 1'b0) begin n_fail++; $display("FAIL midrst_hit0 got=%b want=0", bus.hit_0); end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin tick(); if (bus.ack_0 || bus.busy) seen = 1'b1; end
        n_cmp += 1;
        if (seen) begin n_fail++; $display("FAIL midrst_no_ack got=activity want=none"); end
        $display("mid-scan reset: outputs cleared, aborted request dropped");
        check_req("rerequest", 0, 12'd0, 12'd0, 1'b0, 150, 1'b0);
    endtask

    initial begin
        bus.req_0 = 1'b0; bus.x_0 = '0; bus.y_0 = '0;
        bus.req_1 = 1'b0; bus.x_1 = '0; bus.y_1 = '0;
        test_reset();
        test_early_hit();
        test_edge_contact();
        test_late_wall();
        test_arbitration();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/wall_collision_arbiter.md
# wall_collision_arbiter

Time-shared wall-collision checker for the playfield. Two requesters (hero and partner sprite) each submit a proposed top-left position. The block arbitrates round-robin, scans the 15×10 wall map one tile per clock, and returns a blocked/free verdict per request. It sits between the sprite movement controllers and the wall map, replacing per-sprite free-running collision logic.

## Interface
- SQUARE_SIDE, 60, tile and sprite edge length in pixels
- ORIGIN_X, 62, x pixel of tile column 0
- ORIGIN_Y, 108, y pixel of tile row 0
- MAP_COLS, 15, tile columns
- MAP_ROWS, 10, tile rows

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_0  in  1  requester 0 check request
- x_0, y_0  in  12 each  requester 0 proposed top-left pixel
- req_1  in  1  requester 1 check request
- x_1, y_1  in  12 each  requester 1 proposed top-left pixel
- ack_0, ack_1  out  1  one-cycle result strobe per requester
- hit_0, hit_1  out  1  verdict: 1 = position overlaps a wall; held until that requester's next ack
- busy  out  1  high while not in IDLE

## Operation
- FSM states and transitions:
  - IDLE: if any req_N is high, grant per round-robin, latch that requester's x/y, clear cell index, go to SCAN.
  - SCAN: evaluate one cell per cycle in linear order k = row*MAP_COLS + col, column fastest.
    - Cell is wall and overlaps: go to DONE with result 1.
    - k = 149 with no hit: go to DONE with result 0.
    - Otherwise k increments.
  - DONE: ack of the granted requester high, its hit updated, then go to IDLE.
- Round-robin:
  - Pointer names the preferred requester. After reset it points to 0.
  - After each grant it points to the other requester.
  - A lone request is always granted.
- Overlap test: hx < bx+SQUARE_SIDE && hx+SQUARE_SIDE > bx && hy < by+SQUARE_SIDE && hy+SQUARE_SIDE > by.
  - Strict inequalities, so edge contact is not a hit.
  - All sums use 13-bit unsigned arithmetic, so no wrap occurs for x = 4095.
- Block coordinates: bx = ORIGIN_X + SQUARE_SIDE*col, by = ORIGIN_Y + SQUARE_SIDE*row.
  - Both are maintained by incremental adders (+60 per column, reset to ORIGIN_X on row change). No multipliers.
- Wall map is fixed. Wall tiles at (col,row) = (1,1), (2,1), (1,2), (3,5); all other tiles are free.
- Requester handshake:
  - Hold req_N and coordinates until ack_N.
  - Coordinates are sampled only at grant; later changes are ignored.
  - If req_N is still high in the cycle after ack_N, it is a new request.
- The losing requester's req stays pending and is granted on the next IDLE cycle.

## Timing
- Reset values: ack_0 = ack_1 = 0, hit_0 = hit_1 = 0, busy = 0, state IDLE, RR pointer 0, cell index 0.
- Let E0 be the grant edge, where IDLE goes to SCAN. Cycle n means the n-th cycle after E0.
- Hit at cell k: ack/hit valid in cycle k+1.
- Miss: ack/hit valid in cycle 150. This is the worst case.
- IDLE lasts one cycle after DONE. A back-to-back pending request is granted at the edge ending that IDLE cycle.
- Requests are accepted only in IDLE; req edges during SCAN/DONE wait.
- rst asserted mid-SCAN or in DONE:
  - Next cycle all outputs take their reset values.
  - No ack is issued for the aborted request.
  - The requester must re-request.

## Structure
- Shared package wall_pkg holds:
  - SQUARE_SIDE, ORIGIN_X, ORIGIN_Y, MAP_COLS, MAP_ROWS
  - FSM state encoding (IDLE, SCAN, DONE)
- Sub-module wall_map_rom:
  - Combinational. Input row[3:0], output 15-bit row bitmap, bit col = wall.
  - Out-of-range rows return 0.
  - Reused later by the wall renderer.
- Arbiter, FSM, coordinate accumulators and comparators live in wall_collision_arbiter.

## Test plan
- Early hit: reset, req_0 with (122,168) → ack_0 in cycle 17 after grant, hit_0 = 1 (cell k = 16).
- Edge contact and miss:
  - req_0 with (62,168) → ack_0 in cycle 150, hit_0 = 0.
  - Then (63,168) → hit_0 = 1 at cycle 17.
- Late wall: req_1 with (250,400) → hit_1 = 1, ack_1 in cycle 79 (k = 78).
  - Then (4095,4095) → hit_1 = 0, no overflow false hit.
- Arbitration:
  - req_0 and req_1 rise together after reset → requester 0 served first, requester 1 granted one IDLE cycle after ack_0.
  - Repeat simultaneous requests → requester 1 served first.
- Reset mid-scan: req_0 at (0,0), assert rst in cycle 40 → busy, ack and hit are 0 next cycle, no ack_0 appears.
  - A re-issued request then completes normally at cycle 150.
